cnt_snap_ser: RTL and testbench
===============================

CNT_SNAP_SER -- requirements
Module: cnt_snap_ser

Interface
REQ-001 SHALL have parameter N, default 16: width of the sampled count, range 8..64.
REQ-002 SHALL define derived constant NB = ceil(N/8): number of payload bytes per frame.
REQ-003 SHALL have port clk_i, input, 1: single clock for all logic.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port cnt_i, input, N: free-running event count from the upstream N-bit counter.
REQ-006 SHALL have port snap_i, input, 1: one-cycle request to snapshot cnt_i and emit a frame.
REQ-007 SHALL have port dout_o, output, 8: byte stream toward the USB interface.
REQ-008 SHALL have port dvalid_o, output, 1: dout_o holds a valid byte.
REQ-009 SHALL have port dready_i, input, 1: consumer accepts the byte when dvalid_o=1 and dready_i=1 in the same cycle.
REQ-010 SHALL have port dlast_o, output, 1: current byte is the last byte of the frame.
REQ-011 SHALL have port busy_o, output, 1: a frame is pending or in transfer.

Function
REQ-012 SHALL implement states IDLE, HDR and DATA, with all outputs registered.
REQ-013 In IDLE with snap_i=1 at cycle t, SHALL latch cnt_i sampled at cycle t, enter HDR, and assert dvalid_o and busy_o from cycle t+1.
REQ-014 The frame SHALL be 1 header byte followed by NB payload bytes, MSB first, with the snapshot zero-extended to 8*NB bits.
REQ-015 The header byte SHALL be {4'hA, 2'b00, miss, ovf}, with miss and ovf taken from the sticky flags at the snap cycle.
REQ-016 dout_o, dvalid_o and dlast_o SHALL hold stable while dvalid_o=1 and dready_i=0; no byte is dropped or repeated.
REQ-017 On header acceptance the block SHALL go HDR->DATA and present payload byte 0 in the next cycle.
REQ-018 In DATA, each acceptance SHALL advance a byte index; acceptance of byte NB-1 (with dlast_o=1) SHALL return the block to IDLE.
REQ-019 The block SHALL support one byte per cycle when dready_i is held high, so a frame occupies NB+1 consecutive cycles.
REQ-020 After the last byte is accepted, dvalid_o, dlast_o and busy_o SHALL be 0 in the next cycle; a snap_i in that next cycle starts a new frame.
REQ-021 snap_i SHALL be ignored while busy_o=1, including in the cycle the last byte is accepted; each such ignored request sets the sticky miss flag.
REQ-022 A wrap SHALL be detected as previous-cycle cnt_i equal to all-ones and current cnt_i equal to 0; each wrap sets the sticky ovf flag.
REQ-023 miss and ovf SHALL be copied into the header and cleared on an accepted snap; an event in that same cycle SHALL leave its flag set (the new event wins).
REQ-024 The snapshot register SHALL not change between snap acceptance and frame completion, regardless of cnt_i.
REQ-025 dout_o SHALL be 8'h00 whenever dvalid_o=0.

Reset
REQ-026 While rst_i=1 at a clock edge: state=IDLE, dvalid_o=0, dlast_o=0, busy_o=0, dout_o=0, miss=0, ovf=0, snapshot=0, byte index=0, previous-count register=0.
REQ-027 Reset mid-frame SHALL abort the frame; dvalid_o=0 in the cycle after the reset edge, and no partial frame resumes afterwards.
REQ-028 snap_i in the same cycle as rst_i=1 SHALL be discarded.

Verification
REQ-029 N=16, cnt_i=16'h1234, snap_i pulse, dready_i=1 -> bytes A0, 12, 34 on 3 consecutive cycles, with dlast_o only on 34, then busy_o=0.
REQ-030 Same frame with dready_i toggling 1,0,0,1,... -> identical byte sequence, outputs stable during stalls, cnt_i changes mid-frame not reflected.
REQ-031 cnt_i steps FFFF->0000, then snap at cnt_i=0005 -> A1, 00, 05; a second snap with no wrap -> A0, 00, xx.
REQ-032 snap_i pulsed twice during a frame -> both ignored, next frame header A2; wrap plus snap in the same cycle -> header A0, following frame header A1.
REQ-033 N=12, cnt_i=12'hABC -> A0, 0A, BC; rst_i asserted after header accept -> dvalid_o=0 next cycle, a later snap yields a full fresh frame with flags cleared.

Source files
------------

// File: rtl/cnt_snap_ser.sv
// cnt_snap_ser: snapshot a free-running counter and stream it as a header plus MSB-first payload bytes
module cnt_snap_ser #(
    parameter int N = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] cnt_i,
    input  logic         snap_i,
    output logic [7:0]   dout_o,
    output logic         dvalid_o,
    input  logic         dready_i,
    output logic         dlast_o,
    output logic         busy_o
);
    localparam int NB = (N + 7) / 8;
    localparam int W  = 8 * NB;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t        r_state, w_state_n;
    logic [N-1:0]  r_snap, w_snap_n, r_prev;
    logic [IW-1:0] r_idx, w_idx_n;
    logic [7:0]    r_dout, w_dout_n;
    logic          r_dvalid, w_dvalid_n, r_dlast, w_dlast_n, r_busy, w_busy_n;
    logic          r_miss, w_miss_n, r_ovf, w_ovf_n;
    logic [W-1:0]  w_ext;
    logic          w_acc, w_snap_ok, w_wrap;

    function automatic logic [7:0] get_byte(input logic [W-1:0] v, input int k);
        logic [W-1:0] s;
        s = v >> (8 * (NB - 1 - k));
        return s[7:0];
    endfunction

    assign w_ext     = W'(r_snap);
    assign w_acc     = r_dvalid & dready_i;
    assign w_snap_ok = (r_state == IDLE) & snap_i;
    assign w_wrap    = (r_prev == {N{1'b1}}) && (cnt_i == '0);
    // Flags are cleared by an accepted snap, but a same-cycle event re-sets them
    assign w_miss_n  = (r_miss & ~w_snap_ok) | (snap_i & (r_state != IDLE));
    assign w_ovf_n   = (r_ovf & ~w_snap_ok) | w_wrap;

    always_comb begin
        w_state_n  = r_state;
        w_idx_n    = r_idx;
        w_snap_n   = r_snap;
        w_dout_n   = r_dout;
        w_dvalid_n = r_dvalid;
        w_dlast_n  = r_dlast;
        w_busy_n   = r_busy;
        case (r_state)
            IDLE: if (snap_i) begin
                w_state_n  = HDR;
                w_snap_n   = cnt_i;
                w_idx_n    = '0;
                w_dout_n   = {4'hA, 2'b00, r_miss, r_ovf};
                w_dvalid_n = 1'b1;
                w_dlast_n  = 1'b0;
                w_busy_n   = 1'b1;
            end
            HDR: if (w_acc) begin
                w_state_n = DATA;
                w_idx_n   = '0;
                w_dout_n  = get_byte(w_ext, 0);
                w_dlast_n = (NB == 1);
            end
            DATA: if (w_acc) begin
                if (r_dlast) begin
                    w_state_n  = IDLE;
                    w_idx_n    = '0;
                    w_dout_n   = 8'h00;
                    w_dvalid_n = 1'b0;
                    w_dlast_n  = 1'b0;
                    w_busy_n   = 1'b0;
                end else begin
                    w_idx_n   = r_idx + IW'(1);
                    w_dout_n  = get_byte(w_ext, int'(r_idx) + 1);
                    w_dlast_n = (int'(r_idx) + 2 == NB);
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_snap   <= '0;
            r_prev   <= '0;
            r_idx    <= '0;
            r_dout   <= 8'h00;
            r_dvalid <= 1'b0;
            r_dlast  <= 1'b0;
            r_busy   <= 1'b0;
            r_miss   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_snap   <= w_snap_n;
            r_prev   <= cnt_i;
            r_idx    <= w_idx_n;
            r_dout   <= w_dout_n;
            r_dvalid <= w_dvalid_n;
            r_dlast  <= w_dlast_n;
            r_busy   <= w_busy_n;
            r_miss   <= w_miss_n;
            r_ovf    <= w_ovf_n;
        end
    end

    assign dout_o   = r_dout;
    assign dvalid_o = r_dvalid;
    assign dlast_o  = r_dlast;
    assign busy_o   = r_busy;
endmodule

// File: tb/tb_cnt_snap_ser.sv
// tb_cnt_snap_ser: directed checks of cnt_snap_ser at N=16 (dut a) and N=12 (dut b)
module tb_cnt_snap_ser;
    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] cnt_a = '0;
    logic [11:0] cnt_b = '0;
    logic        snap_a = 1'b0, snap_b = 1'b0, rdy_a = 1'b1, rdy_b = 1'b1;
    logic [7:0]  dout_a, dout_b;
    logic        dv_a, dl_a, bz_a, dv_b, dl_b, bz_b;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    cnt_snap_ser #(.N(16)) u_a (
        .clk_i(clk), .rst_i(rst), .cnt_i(cnt_a), .snap_i(snap_a), .dout_o(dout_a),
        .dvalid_o(dv_a), .dready_i(rdy_a), .dlast_o(dl_a), .busy_o(bz_a)
    );
    cnt_snap_ser #(.N(12)) u_b (
        .clk_i(clk), .rst_i(rst), .cnt_i(cnt_b), .snap_i(snap_b), .dout_o(dout_b),
        .dvalid_o(dv_b), .dready_i(rdy_b), .dlast_o(dl_b), .busy_o(bz_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // packed as {dvalid, dlast, busy, dout}
    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed {dv,dl,bz,dout}=%b_%h expected %b_%h", tag, obs[10:8], obs[7:0], exp[10:8], exp[7:0]);
        end
    endtask

    task automatic ca(input string tag, input logic [2:0] f, input logic [7:0] d);
        chk(tag, {dv_a, dl_a, bz_a, dout_a}, {f, d});
    endtask

    task automatic cb(input string tag, input logic [2:0] f, input logic [7:0] d);
        chk(tag, {dv_b, dl_b, bz_b, dout_b}, {f, d});
    endtask

    initial begin
        snap_a = 1'b1;
        tick(); tick();
        ca("reset_a", 3'b000, 8'h00);
        cb("reset_b", 3'b000, 8'h00);
        rst = 1'b0; snap_a = 1'b0;
        tick();              ca("snap_in_reset_discarded", 3'b000, 8'h00);

        cnt_a = 16'h1234; snap_a = 1'b1;
        tick();              ca("f1_hdr", 3'b101, 8'hA0);
        snap_a = 1'b0; cnt_a = 16'h5555;
        tick();              ca("f1_b0", 3'b101, 8'h12);
        tick();              ca("f1_b1", 3'b111, 8'h34);
        tick();              ca("f1_idle", 3'b000, 8'h00);

        cnt_a = 16'h1234; snap_a = 1'b1;
        tick();              ca("f2_hdr", 3'b101, 8'hA0);
        snap_a = 1'b0; cnt_a = 16'h9999; rdy_a = 1'b0;
        tick();              ca("f2_hdr_stall1", 3'b101, 8'hA0);
        tick();              ca("f2_hdr_stall2", 3'b101, 8'hA0);
        rdy_a = 1'b1;
        tick();              ca("f2_b0", 3'b101, 8'h12);
        rdy_a = 1'b0;
        tick();              ca("f2_b0_stall", 3'b101, 8'h12);
        rdy_a = 1'b1;
        tick();              ca("f2_b1", 3'b111, 8'h34);
        rdy_a = 1'b0;
        tick();              ca("f2_b1_stall", 3'b111, 8'h34);
        rdy_a = 1'b1;
        tick();              ca("f2_idle", 3'b000, 8'h00);

        cnt_a = 16'hFFFF;
        tick();
        cnt_a = 16'h0000;
        tick();              ca("wrap_idle", 3'b000, 8'h00);
        cnt_a = 16'h0005; snap_a = 1'b1;
        tick();              ca("f3_hdr_ovf", 3'b101, 8'hA1);
        snap_a = 1'b0;
        tick();              ca("f3_b0", 3'b101, 8'h00);
        tick();              ca("f3_b1", 3'b111, 8'h05);
        tick();              ca("f3_idle", 3'b000, 8'h00);
        cnt_a = 16'h0006; snap_a = 1'b1;
        tick();              ca("f4_hdr_clear", 3'b101, 8'hA0);
        snap_a = 1'b0;
        tick();              ca("f4_b0", 3'b101, 8'h00);
        tick();              ca("f4_b1", 3'b111, 8'h06);
        tick();              ca("f4_idle", 3'b000, 8'h00);

        cnt_a = 16'h0100; snap_a = 1'b1;
        tick();              ca("f5_hdr", 3'b101, 8'hA0);
        tick();              ca("f5_b0_snap_ignored", 3'b101, 8'h01);
        snap_a = 1'b0;
        tick();              ca("f5_b1", 3'b111, 8'h00);
        snap_a = 1'b1;
        tick();              ca("f5_idle_last_snap_ignored", 3'b000, 8'h00);
        tick();              ca("f6_hdr_miss", 3'b101, 8'hA2);
        snap_a = 1'b0;
        tick();              ca("f6_b0", 3'b101, 8'h01);
        tick();              ca("f6_b1", 3'b111, 8'h00);
        tick();              ca("f6_idle", 3'b000, 8'h00);

        cnt_a = 16'hFFFF;
        tick();
        cnt_a = 16'h0000; snap_a = 1'b1;
        tick();              ca("f7_hdr_wrap_same_cycle", 3'b101, 8'hA0);
        snap_a = 1'b0;
        tick();              ca("f7_b0", 3'b101, 8'h00);
        tick();              ca("f7_b1", 3'b111, 8'h00);
        tick();              ca("f7_idle", 3'b000, 8'h00);
        cnt_a = 16'h0003; snap_a = 1'b1;
        tick();              ca("f8_hdr_ovf_kept", 3'b101, 8'hA1);
        snap_a = 1'b0;
        tick();              ca("f8_b0", 3'b101, 8'h00);
        tick();              ca("f8_b1", 3'b111, 8'h03);
        tick();              ca("f8_idle", 3'b000, 8'h00);

        cnt_b = 12'hABC; snap_b = 1'b1;
        tick();              cb("b1_hdr", 3'b101, 8'hA0);
        snap_b = 1'b0;
        tick();              cb("b1_b0", 3'b101, 8'h0A);
        tick();              cb("b1_b1", 3'b111, 8'hBC);
        tick();              cb("b1_idle", 3'b000, 8'h00);

        snap_b = 1'b1;
        tick();              cb("b2_hdr", 3'b101, 8'hA0);
        tick();              cb("b2_b0_miss", 3'b101, 8'h0A);
        snap_b = 1'b0; rst = 1'b1;
        tick();              cb("b2_abort", 3'b000, 8'h00);
        rst = 1'b0;
        tick();              cb("b2_no_resume", 3'b000, 8'h00);
        cnt_b = 12'h123; snap_b = 1'b1;
        tick();              cb("b3_hdr_fresh", 3'b101, 8'hA0);
        snap_b = 1'b0;
        tick();              cb("b3_b0", 3'b101, 8'h01);
        tick();              cb("b3_b1", 3'b111, 8'h23);
        tick();              cb("b3_idle", 3'b000, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
